// File: rtl/serial_adder.sv
// Digit-serial adder: one DIGIT-bit slice plus a registered carry, iterated WIDTH/DIGIT times.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' port turning the block into a subtractor (cin = borrow-in).
module serial_adder_slice #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
endmodule

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SERIAL_ADDER_SUB_EN
   ,input  logic             sub
`endif
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("serial_adder: DIGIT must be >= 1 and divide WIDTH evenly");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;

    logic [WIDTH-1:0]       a_sh, b_sh, res_sh, res_next, b_in;
    logic [WIDTH+DIGIT-1:0] res_cat;
    logic [CW-1:0]          cnt;
    logic                   carry, carry0, last;
    logic [DIGIT-1:0]       slice_s;
    logic                   slice_co;

`ifdef SERIAL_ADDER_SUB_EN
    // a - b - cin == a + ~b + ~cin, so the slice stays a plain adder
    assign b_in   = sub ? ~b : b;
    assign carry0 = cin ^ sub;
`else
    assign b_in   = b;
    assign carry0 = cin;
`endif

    serial_adder_slice #(.DIGIT(DIGIT)) u_slice (
        .x  (a_sh[DIGIT-1:0]),
        .y  (b_sh[DIGIT-1:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0
    assign res_cat  = {slice_s, res_sh};
    assign res_next = res_cat[WIDTH+DIGIT-1:DIGIT];
    assign last     = (cnt == CW'(NDIG - 1));

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last)      state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_sh  <= a;
                    b_sh  <= b_in;
                    carry <= carry0;
                    cnt   <= '0;
                end
                RUN: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    res_sh <= res_next;
                    carry  <= slice_co;
                    cnt    <= cnt + CW'(1);
                    // sum/cout only move here, so they hold through DONE, IDLE and the next RUN
                    if (last) begin
                        sum  <= res_next;
                        cout <= slice_co;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: 8/1 instance for directed cases, 4/1, 4/2, 4/4 instances for exhaustive sweeps.
module tb_serial_adder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid_d, out_ready_d, cin_d;
    logic [7:0] a_d, b_d;
    int         sel;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub_d;
`endif

    logic       ir0, ov0, co0, bz0;
    logic [7:0] s0;
    logic [2:0] ir4, ov4, co4, bz4;
    logic [3:0] s4 [3];

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid_d && sel == 0), .in_ready(ir0),
        .a(a_d), .b(b_d), .cin(cin_d), .out_valid(ov0), .out_ready(out_ready_d && sel == 0),
        .sum(s0), .cout(co0), .busy(bz0)
`ifdef SERIAL_ADDER_SUB_EN
       ,.sub(sub_d)
`endif
    );

    for (genvar k = 0; k < 3; k++) begin : g_w4
        serial_adder #(.WIDTH(4), .DIGIT(1 << k)) u (
            .clk(clk), .rst(rst), .in_valid(in_valid_d && sel == k + 1), .in_ready(ir4[k]),
            .a(a_d[3:0]), .b(b_d[3:0]), .cin(cin_d), .out_valid(ov4[k]),
            .out_ready(out_ready_d && sel == k + 1), .sum(s4[k]), .cout(co4[k]), .busy(bz4[k])
`ifdef SERIAL_ADDER_SUB_EN
           ,.sub(sub_d)
`endif
        );
    end

    logic       cur_ir, cur_ov, cur_bz;
    logic [8:0] cur_res;
    always_comb begin
        cur_ir = ir0; cur_ov = ov0; cur_bz = bz0; cur_res = {co0, s0};
        for (int k = 0; k < 3; k++)
            if (sel == k + 1) begin
                cur_ir = ir4[k]; cur_ov = ov4[k]; cur_bz = bz4[k];
                cur_res = {4'b0, co4[k], s4[k]};
            end
    end

    int         n_cmp = 0, n_bad = 0;
    logic [8:0] exp_q[$];

    typedef struct {
        logic [7:0] a, b;
        logic       cin;
        logic [8:0] res;   // {cout, sum}
    } vec_t;
    vec_t vecs[6];

    function automatic int lat_of(int s);
        case (s)
            0: return 8;
            1: return 4;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (sel=%0d t=%0t)", nm, act, exp, sel, $time);
        end
    endtask

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [8:0] exp, input bit push);
        int n = 0;
        @(negedge clk);
        while (!cur_ir && n < 50) begin @(negedge clk); n++; end
        chk("in_ready_wait", cur_ir, 1);
        a_d = a; b_d = b; cin_d = c; in_valid_d = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back(exp);
        #1 in_valid_d = 1'b0;
    endtask

    task automatic wait_out();
        int runs = 0, n = 0;
        @(negedge clk);
        while (!cur_ov && n < 50) begin
            if (cur_bz) runs++;
            n++;
            @(negedge clk);
        end
        chk("latency", runs, lat_of(sel));
        chk("out_valid", cur_ov, 1);
    endtask

    task automatic take(int stall);
        logic [8:0] hold;
        hold = cur_res;
        repeat (stall) begin
            @(negedge clk);
            chk("hold_stall", cur_res, hold);
        end
        chk("busy_done", cur_bz, 0);
        out_ready_d = 1'b1;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL result: output %0h with empty scoreboard", cur_res);
        end else if (cur_res !== exp_q[0]) begin
            n_bad++;
            $display("FAIL result: got %0h expected %0h (sel=%0d)", cur_res, exp_q[0], sel);
            void'(exp_q.pop_front());
        end else
            void'(exp_q.pop_front());
        @(posedge clk);
        #1 out_ready_d = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        vecs[0] = '{8'h5A, 8'h33, 1'b0, 9'h08D};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 9'h100};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 9'h000};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 9'h100};
        vecs[5] = '{8'h7F, 8'h00, 1'b1, 9'h080};

        rst = 1'b1; in_valid_d = 0; out_ready_d = 0; cin_d = 0; a_d = 0; b_d = 0; sel = 0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d = 0;
`endif
        repeat (2) @(negedge clk);
        for (int s = 0; s < 4; s++) begin
            sel = s; #1;
            chk("rst_in_ready", cur_ir, 1);
            chk("rst_out_valid", cur_ov, 0);
            chk("rst_busy", cur_bz, 0);
            chk("rst_result", cur_res, 0);
        end
        sel = 0;
        @(negedge clk) rst = 1'b0;

        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, 1);
            wait_out();
            take(0);
        end

        // backpressure: new operands offered during DONE must be ignored
        issue(8'h12, 8'h34, 1'b0, 9'h046, 1);
        wait_out();
        in_valid_d = 1'b1; a_d = 8'hAA; b_d = 8'h55; cin_d = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_hold", cur_res, 9'h046);
            chk("bp_in_ready", cur_ir, 0);
            chk("bp_out_valid", cur_ov, 1);
        end
        take(0);
        a_d = 8'h01; b_d = 8'h02; cin_d = 1'b1;
        @(posedge clk);
        exp_q.push_back(9'h004);
        #1 in_valid_d = 1'b0;
        wait_out();
        take(0);

        // async reset during the third RUN cycle
        issue(8'h5A, 8'h33, 1'b0, 9'h0, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", cur_ov, 0);
        chk("mid_rst_busy", cur_bz, 0);
        chk("mid_rst_result", cur_res, 0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", cur_ir, 1);
        seen = 0;
        repeat (12) begin @(negedge clk); if (cur_ov) seen = 1; end
        chk("no_stale_result", seen, 0);

`ifdef SERIAL_ADDER_SUB_EN
        sub_d = 1'b1;
        issue(8'h10, 8'h01, 1'b0, 9'h10F, 1); wait_out(); take(0);
        issue(8'h00, 8'h01, 1'b0, 9'h0FF, 1); wait_out(); take(0);
        issue(8'h05, 8'h03, 1'b1, 9'h101, 1); wait_out(); take(0);
        sub_d = 1'b0;
`endif

        for (int s = 1; s < 4; s++) begin
            sel = s;
            for (int av = 0; av < 16; av++)
                for (int bv = 0; bv < 16; bv++)
                    for (int cv = 0; cv < 2; cv++) begin
                        issue(8'(av), 8'(bv), 1'(cv), 9'(av + bv + cv), 1);
                        wait_out();
                        take(int'($urandom_range(0, 2)));
                    end
        end

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d results still expected", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
